// File: rtl/sfft_spectrum_reader.sv
`default_nettype none
// ============================================================================
// Module      : sfft_spectrum_reader
// Description : Captures the parallel SFFT spectrum on each OutputValid pulse
//               into a two-bank frame buffer and streams bins 0..NBINS-1 out
//               over a valid/ready interface. Frames arriving while both
//               banks are full are dropped and counted (saturating).
// Option      : SFFT_READER_ABS_EN - when defined, bin_data carries the
//               magnitude of the stored value (most-negative code saturates).
// Revision    : 1.0 - initial release
// ============================================================================
module sfft_spectrum_reader #(
  parameter int NFFT   = 256,
  parameter int DATA_W = 24,
  parameter int NBINS  = NFFT / 2,
  parameter int DROP_W = 8,
  localparam int IDX_W = (NBINS > 1) ? $clog2(NBINS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NFFT-1:0][DATA_W-1:0]  SFFT_In,
  input  logic                         OutputValid,
  output logic [DATA_W-1:0]            bin_data,
  output logic [IDX_W-1:0]             bin_index,
  output logic                         bin_valid,
  input  logic                         bin_ready,
  output logic                         bin_last,
  output logic [15:0]                  frame_count,
  output logic [DROP_W-1:0]            dropped_frames
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBINS - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                rd_sel_q, rd_sel_d;
  logic                wr_sel_q, wr_sel_d;
  logic [1:0]          full_q, full_d;
  logic [15:0]         frame_q, frame_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                release_bank;
  logic                capture;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   out_word;

  logic [DATA_W-1:0]   bank_q [2][NBINS];

  // Bins above NBINS are not buffered; fold them into a deliberately unused net.
  generate
    if (NBINS < NFFT) begin : g_unused_hi
      logic unused_hi_bins;
      assign unused_hi_bins = ^SFFT_In[NFFT-1:NBINS];
    end
  endgenerate

  // Stream FSM: advance the bin pointer on handshake and retire a bank on its last bin.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rd_sel_d     = rd_sel_q;
    release_bank = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|full_q) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (bin_ready) begin
          if (ptr_q == LAST_IDX) begin
            release_bank = 1'b1;
            ptr_d        = '0;
            rd_sel_d     = ~rd_sel_q;
            if (!full_q[~rd_sel_q]) state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bank bookkeeping: a bank being released this edge may be refilled on the same edge.
  always_comb begin
    capture = OutputValid &&
              (!full_q[wr_sel_q] || (release_bank && (rd_sel_q == wr_sel_q)));
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    frame_d  = frame_q;
    drop_d   = drop_q;
    if (release_bank) begin
      full_d[rd_sel_q] = 1'b0;
      frame_d          = frame_q + 16'd1;
    end
    if (capture) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end else if (OutputValid && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      rd_sel_q <= 1'b0;
      wr_sel_q <= 1'b0;
      full_q   <= '0;
      frame_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rd_sel_q <= rd_sel_d;
      wr_sel_q <= wr_sel_d;
      full_q   <= full_d;
      frame_q  <= frame_d;
      drop_q   <= drop_d;
    end
  end

  // Frame storage: contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NBINS; k++) begin
        bank_q[wr_sel_q][k] <= SFFT_In[k];
      end
    end
  end

  assign rd_word = bank_q[rd_sel_q][ptr_q];

`ifdef SFFT_READER_ABS_EN
  // Magnitude at the output mux; the most-negative code has no positive twin, so clamp it.
  always_comb begin
    if (rd_word == {1'b1, {(DATA_W-1){1'b0}}}) begin
      out_word = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (rd_word[DATA_W-1]) begin
      out_word = -rd_word;
    end else begin
      out_word = rd_word;
    end
  end
`else
  assign out_word = rd_word;
`endif

  assign bin_valid      = (state_q == ST_STREAM);
  assign bin_index      = ptr_q;
  assign bin_last       = bin_valid && (ptr_q == LAST_IDX);
  assign bin_data       = bin_valid ? out_word : '0;
  assign frame_count    = frame_q;
  assign dropped_frames = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_sfft_spectrum_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfft_spectrum_reader
// Description : Directed self-checking bench for sfft_spectrum_reader.
//               Honours SFFT_READER_ABS_EN for the data-path expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfft_spectrum_reader;

  localparam int NFFT   = 256;
  localparam int DATA_W = 24;
  localparam int NBINS  = 128;
  localparam int DROP_W = 8;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NFFT-1:0][DATA_W-1:0] sfft;
  logic                        ov;
  logic [DATA_W-1:0]           bin_data;
  logic [6:0]                  bin_index;
  logic                        bin_valid;
  logic                        bin_ready;
  logic                        bin_last;
  logic [15:0]                 frame_count;
  logic [DROP_W-1:0]           dropped_frames;

  int n_pass  = 0;
  int n_total = 0;

  sfft_spectrum_reader #(
    .NFFT(NFFT), .DATA_W(DATA_W), .NBINS(NBINS), .DROP_W(DROP_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .SFFT_In(sfft),
    .OutputValid(ov),
    .bin_data(bin_data),
    .bin_index(bin_index),
    .bin_valid(bin_valid),
    .bin_ready(bin_ready),
    .bin_last(bin_last),
    .frame_count(frame_count),
    .dropped_frames(dropped_frames)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic load(input logic [23:0] base);
    for (int k = 0; k < NFFT; k++) sfft[k] = base + 24'(k);
  endtask

  // Expect one whole frame base+0..base+127 starting at the next negedge.
  // stall selects the 1,0,0,1 ready pattern; inj pulses a new frame on the last handshake.
  task automatic drain(input logic [23:0] base, input bit stall,
                       input bit inj, input logic [23:0] inj_base);
    int k = 0;
    int c = 0;
    logic rdy;
    while (k < NBINS && c < 1000) begin
      @(negedge clk);
      ov = 1'b0;
      check("valid", {31'b0, bin_valid}, 32'd1);
      check("index", {25'b0, bin_index}, 32'(k));
      check("data",  {8'b0, bin_data}, {8'b0, base + 24'(k)});
      check("last",  {31'b0, bin_last}, {31'b0, (k == NBINS-1)});
      case (c % 4)
        1, 2:    rdy = !stall;
        default: rdy = 1'b1;
      endcase
      bin_ready = rdy;
      if (inj && rdy && k == NBINS-1) begin
        load(inj_base);
        ov = 1'b1;
      end
      if (bin_valid && rdy) k++;
      c++;
    end
    if (k < NBINS) check("drain_timeout", 32'(k), 32'(NBINS));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp6 [3];
    bit found;
    reset = 1'b1; ov = 1'b0; bin_ready = 1'b0; load(24'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_valid", {31'b0, bin_valid}, 32'd0);
    check("rst_index", {25'b0, bin_index}, 32'd0);
    check("rst_data",  {8'b0, bin_data}, 32'd0);
    check("rst_last",  {31'b0, bin_last}, 32'd0);
    check("rst_frames", {16'b0, frame_count}, 32'd0);
    check("rst_drops", {24'b0, dropped_frames}, 32'd0);

    // 1: single frame, ready always high.
    @(negedge clk); load(24'h0); ov = 1'b1; bin_ready = 1'b1;
    @(negedge clk); ov = 1'b0;
    check("t1_latency", {31'b0, bin_valid}, 32'd0);
    drain(24'h0, 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    check("t1_idle", {31'b0, bin_valid}, 32'd0);
    check("t1_frames", {16'b0, frame_count}, 32'd1);

    // 2: stalled readout.
    load(24'h1000); ov = 1'b1;
    @(negedge clk); ov = 1'b0;
    check("t2_latency", {31'b0, bin_valid}, 32'd0);
    drain(24'h1000, 1'b1, 1'b0, 24'h0);
    @(negedge clk);
    check("t2_idle", {31'b0, bin_valid}, 32'd0);
    check("t2_frames", {16'b0, frame_count}, 32'd2);
    check("t2_drops", {24'b0, dropped_frames}, 32'd0);

    // 3: three frames against a blocked reader; C is dropped.
    bin_ready = 1'b0; load(24'h2000); ov = 1'b1;
    @(negedge clk); load(24'h3000);
    @(negedge clk); load(24'h4000);
    @(negedge clk); ov = 1'b0;
    check("t3_drops", {24'b0, dropped_frames}, 32'd1);
    check("t3_valid", {31'b0, bin_valid}, 32'd1);
    drain(24'h2000, 1'b0, 1'b0, 24'h0);
    drain(24'h3000, 1'b0, 1'b0, 24'h0);
    repeat (3) begin
      @(negedge clk);
      check("t3_no_c", {31'b0, bin_valid}, 32'd0);
    end
    check("t3_frames", {16'b0, frame_count}, 32'd4);

    // 4: both banks full, new frame lands on the last-bin handshake.
    bin_ready = 1'b0; load(24'h5000); ov = 1'b1;
    @(negedge clk); load(24'h6000);
    @(negedge clk); ov = 1'b0;
    drain(24'h5000, 1'b0, 1'b1, 24'h7000);
    drain(24'h6000, 1'b0, 1'b0, 24'h0);
    drain(24'h7000, 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    check("t4_idle", {31'b0, bin_valid}, 32'd0);
    check("t4_drops", {24'b0, dropped_frames}, 32'd1);
    check("t4_frames", {16'b0, frame_count}, 32'd7);

    // 5: reset in the middle of a frame.
    load(24'h8000); ov = 1'b1; bin_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); ov = 1'b0;
      if (bin_valid && bin_index == 7'd40) found = 1'b1;
    end
    check("t5_reach40", {31'b0, found}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t5_valid", {31'b0, bin_valid}, 32'd0);
    check("t5_index", {25'b0, bin_index}, 32'd0);
    check("t5_frames", {16'b0, frame_count}, 32'd0);
    check("t5_drops", {24'b0, dropped_frames}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); load(24'h9000); ov = 1'b1;
    @(negedge clk); ov = 1'b0;
    check("t5_latency", {31'b0, bin_valid}, 32'd0);
    drain(24'h9000, 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    check("t5_frames_after", {16'b0, frame_count}, 32'd1);

    // 6: signed data path.
`ifdef SFFT_READER_ABS_EN
    exp6[0] = 24'h000005; exp6[1] = 24'h7FFFFF; exp6[2] = 24'h000007;
`else
    exp6[0] = 24'hFFFFFB; exp6[1] = 24'h800000; exp6[2] = 24'h000007;
`endif
    load(24'h0);
    sfft[0] = 24'hFFFFFB; sfft[1] = 24'h800000; sfft[2] = 24'h000007;
    ov = 1'b1; bin_ready = 1'b1;
    @(negedge clk); ov = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("t6_index", {25'b0, bin_index}, 32'(j));
      check("t6_data", {8'b0, bin_data}, {8'b0, exp6[j]});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
